uart_tx_fifo: RTL and testbench

Buffered UART transmitter for the `riscv_unit` SoC peripheral bus. Write-side peripheral logic pushes bytes through a valid/ready port into an internal FIFO. A frame FSM serialises each byte onto `tx_o` as 1 start bit, 8 data bits LSB-first, an optional even-parity bit (XOR of the data bits) and 1 or 2 stop bits. It is the stage that drives the SoC `tx_o` pin sampled by the system-level UART monitor.

---
 rtl/uart_tx_fifo.sv | 233 +++++++++++++++++++++++
 tb/tb_uart_tx_fifo.sv | 268 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_fifo.sv
`default_nettype none
// ============================================================================
//  Module   : uart_tx_fifo
//  Purpose  : Buffered UART transmitter. Bytes are pushed through a
//             valid/ready port into a circular FIFO. A frame FSM serialises
//             each byte as start bit, 8 data bits LSB-first, an optional
//             even-parity bit and 1 or 2 stop bits.
//  Ports    : clk_i, rst_i (async, active-high)
//             tx_data_i / tx_valid_i / tx_ready_o : byte push port
//             baud_div_i   : clocks per bit (0 behaves as 1)
//             parity_en_i  : insert even-parity bit
//             stopbits_i   : 0 = one stop bit, 1 = two stop bits
//             tx_o         : serial line, idles high, driven from a flop
//             busy_o       : frame in progress or FIFO not empty
//             fifo_count_o : FIFO occupancy
//  Revision : 1.0  initial release
// ============================================================================
module uart_tx_fifo #(
  parameter int FIFO_DEPTH = 4
) (
  input  logic                          clk_i,
  input  logic                          rst_i,
  input  logic [7:0]                    tx_data_i,
  input  logic                          tx_valid_i,
  output logic                          tx_ready_o,
  input  logic [15:0]                   baud_div_i,
  input  logic                          parity_en_i,
  input  logic                          stopbits_i,
  output logic                          tx_o,
  output logic                          busy_o,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count_o
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] FULL_COUNT = CW'(FIFO_DEPTH);

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_STOP   = 3'd4
  } state_t;

  // --------------------------------------------------------------------------
  // FIFO storage and pointers
  // --------------------------------------------------------------------------
  logic [7:0]    mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [CW-1:0] count;
  logic          push;
  logic          pop;
  logic          fifo_nonempty;
  logic [7:0]    head;

  assign tx_ready_o    = (count != FULL_COUNT);
  assign push          = tx_valid_i && tx_ready_o;
  assign fifo_nonempty = (count != '0);
  assign head          = mem[rd_ptr];
  assign fifo_count_o  = count;

  // Storage needs no reset: pointers and count define which entries are live.
  always_ff @(posedge clk_i) begin
    if (push) begin
      mem[wr_ptr] <= tx_data_i;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + AW'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + AW'(1);
      end
      // Simultaneous push and pop leaves the occupancy unchanged.
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  // --------------------------------------------------------------------------
  // Frame FSM and datapath registers
  // --------------------------------------------------------------------------
  state_t      state, state_n;
  logic [7:0]  shift, shift_n;
  logic        parity_bit, parity_n;
  logic [15:0] cfg_div, cfg_div_n;
  logic        cfg_par, cfg_par_n;
  logic        cfg_stop2, cfg_stop2_n;
  logic [15:0] baud_cnt, baud_n;
  logic [2:0]  bit_cnt, bit_n;
  logic        stop_second, stop_second_n;
  logic        tx_reg, tx_n;
  logic        load;
  logic        bit_end;

  // cfg_div is never zero while a frame is active, so D-1 cannot underflow
  // in any state where bit_end is used.
  assign bit_end = (baud_cnt == (cfg_div - 16'd1));

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state       <= ST_IDLE;
      shift       <= '0;
      parity_bit  <= 1'b0;
      cfg_div     <= '0;
      cfg_par     <= 1'b0;
      cfg_stop2   <= 1'b0;
      baud_cnt    <= '0;
      bit_cnt     <= '0;
      stop_second <= 1'b0;
      tx_reg      <= 1'b1;
    end else begin
      state       <= state_n;
      shift       <= shift_n;
      parity_bit  <= parity_n;
      cfg_div     <= cfg_div_n;
      cfg_par     <= cfg_par_n;
      cfg_stop2   <= cfg_stop2_n;
      baud_cnt    <= baud_n;
      bit_cnt     <= bit_n;
      stop_second <= stop_second_n;
      tx_reg      <= tx_n;
    end
  end

  always_comb begin
    state_n       = state;
    shift_n       = shift;
    parity_n      = parity_bit;
    cfg_div_n     = cfg_div;
    cfg_par_n     = cfg_par;
    cfg_stop2_n   = cfg_stop2;
    baud_n        = baud_cnt;
    bit_n         = bit_cnt;
    stop_second_n = stop_second;
    load          = 1'b0;
    pop           = 1'b0;
    tx_n          = 1'b1;

    case (state)
      ST_IDLE: begin
        if (fifo_nonempty) begin
          load = 1'b1;
        end
      end
      ST_START: begin
        if (bit_end) begin
          state_n = ST_DATA;
          bit_n   = 3'd0;
        end
      end
      ST_DATA: begin
        if (bit_end) begin
          shift_n = {1'b0, shift[7:1]};
          if (bit_cnt == 3'd7) begin
            bit_n         = 3'd0;
            stop_second_n = 1'b0;
            state_n       = cfg_par ? ST_PARITY : ST_STOP;
          end else begin
            bit_n = bit_cnt + 3'd1;
          end
        end
      end
      ST_PARITY: begin
        if (bit_end) begin
          state_n       = ST_STOP;
          stop_second_n = 1'b0;
        end
      end
      ST_STOP: begin
        if (bit_end) begin
          // Two stop bits are sent as two consecutive D-cycle periods.
          if (cfg_stop2 && !stop_second) begin
            stop_second_n = 1'b1;
          end else if (fifo_nonempty) begin
            load = 1'b1;
          end else begin
            state_n = ST_IDLE;
          end
        end
      end
      default: begin
        state_n = ST_IDLE;
      end
    endcase

    // Baud counter runs only inside a frame and restarts at every bit boundary.
    if (state == ST_IDLE) begin
      baud_n = '0;
    end else begin
      baud_n = bit_end ? 16'd0 : (baud_cnt + 16'd1);
    end

    // Frame start: pop the head, snapshot the line configuration.
    if (load) begin
      pop           = 1'b1;
      state_n       = ST_START;
      shift_n       = head;
      parity_n      = ^head;
      cfg_div_n     = (baud_div_i == 16'd0) ? 16'd1 : baud_div_i;
      cfg_par_n     = parity_en_i;
      cfg_stop2_n   = stopbits_i;
      baud_n        = '0;
      bit_n         = 3'd0;
      stop_second_n = 1'b0;
    end

    // Line level is a function of the next state so that tx_o is a pure flop.
    case (state_n)
      ST_START:  tx_n = 1'b0;
      ST_DATA:   tx_n = shift_n[0];
      ST_PARITY: tx_n = parity_n;
      default:   tx_n = 1'b1;
    endcase
  end

  assign tx_o   = tx_reg;
  assign busy_o = (state != ST_IDLE) || fifo_nonempty;

endmodule
`default_nettype wire

// File: tb/tb_uart_tx_fifo.sv
`default_nettype none
// ============================================================================
//  Module   : tb_uart_tx_fifo
//  Purpose  : Scoreboard bench for uart_tx_fifo. Each push queues the expected
//             frame (byte, hand-computed parity, latched config); a line
//             monitor decodes tx and compares every bit period.
//  Revision : 1.0  initial release
// ============================================================================
module tb_uart_tx_fifo;

  logic        clk = 1'b0;
  logic        rst;
  logic [7:0]  tx_data;
  logic        tx_valid;
  logic        tx_ready;
  logic [15:0] baud_div;
  logic        parity_en;
  logic        stopbits;
  logic        tx;
  logic        busy;
  logic [2:0]  fifo_count;

  uart_tx_fifo #(.FIFO_DEPTH(4)) dut (
    .clk_i        (clk),
    .rst_i        (rst),
    .tx_data_i    (tx_data),
    .tx_valid_i   (tx_valid),
    .tx_ready_o   (tx_ready),
    .baud_div_i   (baud_div),
    .parity_en_i  (parity_en),
    .stopbits_i   (stopbits),
    .tx_o         (tx),
    .busy_o       (busy),
    .fifo_count_o (fifo_count)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [7:0] data;
    logic       par_en;
    logic       par;
    logic       stop2;
    int         div;
  } frame_t;

  frame_t sb[$];
  int     start_q[$];
  int     tests_run    = 0;
  int     tests_failed = 0;
  bit     mon_en       = 1'b1;
  bit     mon_busy     = 1'b0;
  int     push_cyc     = 0;

  task automatic chk(input string nm, input longint act, input longint exp);
    tests_run++;
    if (act !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Called at #1 after a rising edge. When track is set the expected frame
  // (with the caller's hand-computed parity) goes into the scoreboard.
  task automatic push(input logic [7:0] d, input logic ep, input bit track);
    int g = 0;
    tx_data  = d;
    tx_valid = 1'b1;
    while (!tx_ready && g < 2000) begin
      tick(1);
      g++;
    end
    if (g >= 2000) chk("push_ready_timeout", 0, 1);
    @(posedge clk);
    #1;
    push_cyc = cyc;
    tx_valid = 1'b0;
    if (track) begin
      sb.push_back('{data: d, par_en: parity_en, par: ep, stop2: stopbits,
                     div: (baud_div == 16'd0) ? 1 : int'(baud_div)});
    end
  endtask

  task automatic wait_done(input string nm);
    int g = 0;
    while ((sb.size() != 0 || mon_busy || busy) && g < 3000) begin
      tick(1);
      g++;
    end
    if (g >= 3000) chk({nm, "_done_timeout"}, 0, 1);
  endtask

  // Line monitor: samples on falling edges, a low level while idle marks the
  // first cycle of a start bit.
  initial begin
    frame_t f;
    logic   bits[12];
    int     nb;
    int     fidx = 0;
    logic   got;
    forever begin
      @(negedge clk);
      if (!mon_en || tx !== 1'b0) continue;
      if (sb.size() == 0) begin
        chk("unexpected_frame", 1, 0);
        for (int w = 0; w < 1000 && tx === 1'b0; w++) @(negedge clk);
        continue;
      end
      mon_busy = 1'b1;
      start_q.push_back(cyc);
      f = sb.pop_front();
      bits[0] = 1'b0;
      for (int i = 0; i < 8; i++) bits[1+i] = f.data[i];
      nb = 9;
      if (f.par_en) begin bits[nb] = f.par; nb++; end
      bits[nb] = 1'b1; nb++;
      if (f.stop2) begin bits[nb] = 1'b1; nb++; end
      for (int b = 0; b < nb; b++) begin
        got = bits[b];
        for (int c = 0; c < f.div; c++) begin
          if (!(b == 0 && c == 0)) @(negedge clk);
          if (tx !== bits[b]) got = tx;
        end
        chk($sformatf("frame%0d_bit%0d", fidx, b), got, bits[b]);
      end
      fidx++;
      mon_busy = 1'b0;
    end
  end

  initial begin
    #900_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int   g;
    int   bad;
    int   lows;
    rst       = 1'b1;
    tx_data   = 8'h00;
    tx_valid  = 1'b0;
    baud_div  = 16'd4;
    parity_en = 1'b1;
    stopbits  = 1'b0;
    tick(3);
    rst = 1'b0;
    tick(1);

    // Reset state
    chk("rst_tx", tx, 1);
    chk("rst_ready", tx_ready, 1);
    chk("rst_busy", busy, 0);
    chk("rst_count", fifo_count, 0);

    // 0x55, D=4, parity on (4 ones -> 0), one stop: 11 bits * 4 = 44 cycles,
    // pop one edge after the push, so busy drops 45 edges after the push.
    push(8'h55, 1'b0, 1'b1);
    chk("t1_count_after_push", fifo_count, 1);
    chk("t1_busy_after_push", busy, 1);
    g = 0;
    while (busy && g < 200) begin tick(1); g++; end
    chk("t1_busy_len", cyc - push_cyc, 45);
    wait_done("t1");

    // 0xA7 has 5 ones -> parity 1
    push(8'hA7, 1'b1, 1'b1);
    wait_done("t2");

    // D=2, no parity, two stop bits, back-to-back frames
    baud_div  = 16'd2;
    parity_en = 1'b0;
    stopbits  = 1'b1;
    start_q.delete();
    push(8'h00, 1'b0, 1'b1);
    push(8'hFF, 1'b0, 1'b1);
    wait_done("t3");
    chk("t3_frames_seen", start_q.size(), 2);
    // (1 start + 8 data + 2 stop) * 2 = 22 cycles between start bits
    if (start_q.size() == 2) chk("t3_gap", start_q[1] - start_q[0], 22);

    // FIFO full, D=8
    baud_div = 16'd8;
    stopbits = 1'b0;
    push(8'h10, 1'b0, 1'b1);
    push(8'h21, 1'b0, 1'b1);
    push(8'h32, 1'b0, 1'b1);
    push(8'h43, 1'b0, 1'b1);
    push(8'h54, 1'b0, 1'b1);
    chk("t4_count_full", fifo_count, 4);
    chk("t4_ready_full", tx_ready, 0);
    bad = 0;
    g = 0;
    while (fifo_count == 3'd4 && g < 1000) begin
      if (tx_ready) bad = 1;
      tick(1);
      g++;
    end
    chk("t4_ready_low_while_full", bad, 0);
    chk("t4_count_after_pop", fifo_count, 3);
    chk("t4_ready_after_pop", tx_ready, 1);
    wait_done("t4");

    // Reset mid-frame during data bit 3 (0x35: bit3 = 0), second byte queued
    baud_div = 16'd4;
    mon_en   = 1'b0;
    push(8'h35, 1'b0, 1'b0);
    push(8'h11, 1'b0, 1'b0);
    // Pop at push+1, bit3 spans 4 cycles starting 16 cycles after the pop.
    tick(17);
    chk("t5_tx_in_bit3", tx, 0);
    chk("t5_count_before_rst", fifo_count, 1);
    #2;
    rst = 1'b1;
    #1;
    chk("t5_rst_tx", tx, 1);
    chk("t5_rst_count", fifo_count, 0);
    chk("t5_rst_busy", busy, 0);
    chk("t5_rst_ready", tx_ready, 1);
    tick(2);
    rst = 1'b0;
    lows = 0;
    for (int i = 0; i < 60; i++) begin
      tick(1);
      if (tx !== 1'b1) lows++;
    end
    chk("t5_no_frame_after_rst", lows, 0);
    chk("t5_idle_after_rst", busy, 0);
    mon_en    = 1'b1;
    parity_en = 1'b1;
    push(8'h81, 1'b0, 1'b1);   // two ones -> parity 0
    wait_done("t5");

    // D=0 behaves as 1-cycle bits; 0x96 has four ones -> parity 0
    baud_div = 16'd0;
    push(8'h96, 1'b0, 1'b1);
    wait_done("t6a");

    // Mid-frame config change: frame 1 keeps D=3/no parity, frame 2 uses
    // D=5/parity on; 0x5B has five ones -> parity 1
    baud_div  = 16'd3;
    parity_en = 1'b0;
    push(8'hC3, 1'b0, 1'b1);
    tick(5);
    baud_div  = 16'd5;
    parity_en = 1'b1;
    push(8'h5B, 1'b1, 1'b1);
    wait_done("t6b");

    chk("final_sb_empty", sb.size(), 0);
    chk("final_idle", busy, 0);
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
`default_nettype wire
